// File: rtl/rggen_wait_state_register.sv
// Single-register front end: address decode, programmable read/write wait states,
// permission checking, one-cycle field access pulses and a registered response.
module rggen_wait_state_register #(
  parameter int                       ADDRESS_WIDTH   = 16,
  parameter logic [ADDRESS_WIDTH-1:0] START_ADDRESS   = '0,
  parameter logic [ADDRESS_WIDTH-1:0] END_ADDRESS     = '0,
  parameter int                       DATA_WIDTH      = 32,
  parameter logic [DATA_WIDTH-1:0]    VALID_BITS      = '1,
  parameter bit                       READABLE        = 1'b1,
  parameter bit                       WRITABLE        = 1'b1,
  parameter int                       READ_WAIT       = 0,
  parameter int                       WRITE_WAIT      = 0,
  parameter bit                       ERROR_ON_DENIED = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_request,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic                     i_write,
  input  logic [DATA_WIDTH-1:0]    i_write_data,
  input  logic [DATA_WIDTH/8-1:0]  i_strobe,
  output logic                     o_select,
  output logic                     o_ready,
  output logic [1:0]               o_status,
  output logic [DATA_WIDTH-1:0]    o_read_data,
  output logic                     o_field_read_valid,
  output logic                     o_field_write_valid,
  output logic [DATA_WIDTH-1:0]    o_field_write_data,
  output logic [DATA_WIDTH-1:0]    o_field_write_mask,
  input  logic [DATA_WIDTH-1:0]    i_field_read_data,
  output logic [1:0]               o_state
);

  localparam int LSB      = $clog2(DATA_WIDTH / 8);
  localparam int WORD_W   = ADDRESS_WIDTH - LSB;
  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CW       = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [WORD_W-1:0] START_WORD = START_ADDRESS[ADDRESS_WIDTH-1:LSB];
  localparam logic [WORD_W-1:0] END_WORD   = END_ADDRESS[ADDRESS_WIDTH-1:LSB];

  localparam logic [CW-1:0] READ_LOAD  = (READ_WAIT > 0)  ? CW'(READ_WAIT - 1)  : '0;
  localparam logic [CW-1:0] WRITE_LOAD = (WRITE_WAIT > 0) ? CW'(WRITE_WAIT - 1) : '0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_ACCESS  = 2'd2;
  localparam logic [1:0] ST_RESPOND = 2'd3;

  // Handshake: i_request is held by the host until o_ready; o_ready is a
  // single-cycle strobe and o_read_data/o_status are valid only with it.
  // A request still high in the cycle after the strobe starts a new access.

  logic [1:0]            state;
  logic [CW-1:0]         count;
  logic                  write_q;
  logic                  denied_q;
  logic [DATA_WIDTH-1:0] capture_q;
  logic [DATA_WIDTH-1:0] strobe_mask;
  logic [WORD_W-1:0]     word;
  logic                  hit;
  logic                  denied;
  logic                  wait_zero;

  assign word    = i_address[ADDRESS_WIDTH-1:LSB];
  assign o_state = state;

  generate
    if (START_WORD == END_WORD) begin : g_single
      assign o_select = (word == START_WORD);
    end else if (START_WORD == '0) begin : g_from_zero
      assign o_select = (word <= END_WORD);
    end else begin : g_range
      assign o_select = (word >= START_WORD) && (word <= END_WORD);
    end

    if (LSB > 0) begin : g_unused_lsb
      logic unused_address_lsb;
      assign unused_address_lsb = ^i_address[LSB-1:0];
    end
  endgenerate

  always_comb begin
    strobe_mask = '0;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      strobe_mask[i*8 +: 8] = {8{i_strobe[i]}};
    end
  end

  assign hit       = i_request && o_select;
  assign denied    = i_write ? !WRITABLE : !READABLE;
  assign wait_zero = i_write ? (WRITE_WAIT == 0) : (READ_WAIT == 0);

  // Outputs trail the state by one edge: the pulse is visible while the
  // FSM sits in RESPOND, the ready strobe while it is back in IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state               <= ST_IDLE;
      count               <= '0;
      write_q             <= 1'b0;
      denied_q            <= 1'b0;
      capture_q           <= '0;
      o_ready             <= 1'b0;
      o_status            <= 2'b00;
      o_read_data         <= '0;
      o_field_read_valid  <= 1'b0;
      o_field_write_valid <= 1'b0;
      o_field_write_data  <= '0;
      o_field_write_mask  <= '0;
    end else begin
      o_ready             <= 1'b0;
      o_status            <= 2'b00;
      o_read_data         <= '0;
      o_field_read_valid  <= 1'b0;
      o_field_write_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (hit) begin
            write_q            <= i_write;
            denied_q           <= denied;
            o_field_write_data <= i_write_data & VALID_BITS;
            o_field_write_mask <= strobe_mask & VALID_BITS;
            if (denied) begin
              state <= ST_RESPOND;
            end else if (wait_zero) begin
              state <= ST_ACCESS;
            end else begin
              count <= i_write ? WRITE_LOAD : READ_LOAD;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!i_request) begin
            count <= '0;
            state <= ST_IDLE;
          end else if (count == '0) begin
            state <= ST_ACCESS;
          end else begin
            count <= count - 1'b1;
          end
        end
        ST_ACCESS: begin
          o_field_read_valid  <= !write_q;
          o_field_write_valid <= write_q;
          if (!write_q) begin
            capture_q <= i_field_read_data & VALID_BITS;
          end
          state <= ST_RESPOND;
        end
        ST_RESPOND: begin
          o_ready     <= 1'b1;
          o_status    <= (denied_q && ERROR_ON_DENIED) ? 2'b10 : 2'b00;
          o_read_data <= (!write_q && !denied_q) ? capture_q : '0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_wait_state_register.sv
// Directed bench for rggen_wait_state_register: three configurations share one
// bus; expected values are hand-computed constants and a read-data queue.
module tb_rggen_wait_state_register;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] address = '0;
  logic        write = 1'b0;
  logic [31:0] write_data = '0;
  logic [3:0]  strobe = '0;
  logic [31:0] field_read_data = '0;
  logic        req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;

  logic        sel_a, rdy_a, frv_a, fwv_a;
  logic [1:0]  sts_a, st_a;
  logic [31:0] rd_a, fwd_a, fwm_a;
  logic        sel_b, rdy_b, frv_b, fwv_b;
  logic [1:0]  sts_b, st_b;
  logic [31:0] rd_b, fwd_b, fwm_b;
  logic        sel_c, rdy_c, frv_c, fwv_c;
  logic [1:0]  sts_c, st_c;
  logic [31:0] rd_c, fwd_c, fwm_c;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  rggen_wait_state_register #(
    .ADDRESS_WIDTH(16), .START_ADDRESS(16'h0010), .END_ADDRESS(16'h001C),
    .DATA_WIDTH(32), .VALID_BITS(32'hFFFF_FFFF), .READABLE(1'b1), .WRITABLE(1'b1),
    .READ_WAIT(1), .WRITE_WAIT(3), .ERROR_ON_DENIED(1'b1)
  ) u_a (
    .i_clk(clk), .i_rst(rst), .i_request(req_a), .i_address(address), .i_write(write),
    .i_write_data(write_data), .i_strobe(strobe), .o_select(sel_a), .o_ready(rdy_a),
    .o_status(sts_a), .o_read_data(rd_a), .o_field_read_valid(frv_a),
    .o_field_write_valid(fwv_a), .o_field_write_data(fwd_a), .o_field_write_mask(fwm_a),
    .i_field_read_data(field_read_data), .o_state(st_a)
  );

  rggen_wait_state_register #(
    .ADDRESS_WIDTH(16), .START_ADDRESS(16'h0040), .END_ADDRESS(16'h0040),
    .DATA_WIDTH(32), .VALID_BITS(32'hFFFF_FFFF), .READABLE(1'b1), .WRITABLE(1'b0),
    .READ_WAIT(5), .WRITE_WAIT(0), .ERROR_ON_DENIED(1'b1)
  ) u_b (
    .i_clk(clk), .i_rst(rst), .i_request(req_b), .i_address(address), .i_write(write),
    .i_write_data(write_data), .i_strobe(strobe), .o_select(sel_b), .o_ready(rdy_b),
    .o_status(sts_b), .o_read_data(rd_b), .o_field_read_valid(frv_b),
    .o_field_write_valid(fwv_b), .o_field_write_data(fwd_b), .o_field_write_mask(fwm_b),
    .i_field_read_data(field_read_data), .o_state(st_b)
  );

  rggen_wait_state_register #(
    .ADDRESS_WIDTH(16), .START_ADDRESS(16'h0040), .END_ADDRESS(16'h0040),
    .DATA_WIDTH(32), .VALID_BITS(32'h0000_FFFF), .READABLE(1'b1), .WRITABLE(1'b0),
    .READ_WAIT(0), .WRITE_WAIT(0), .ERROR_ON_DENIED(1'b0)
  ) u_c (
    .i_clk(clk), .i_rst(rst), .i_request(req_c), .i_address(address), .i_write(write),
    .i_write_data(write_data), .i_strobe(strobe), .o_select(sel_c), .o_ready(rdy_c),
    .o_status(sts_c), .o_read_data(rd_c), .o_field_read_valid(frv_c),
    .o_field_write_valid(fwv_c), .o_field_write_data(fwd_c), .o_field_write_mask(fwm_c),
    .i_field_read_data(field_read_data), .o_state(st_c)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks: each tick lands 1ns after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] stb);
    address    = addr;
    write      = wr;
    write_data = wd;
    strobe     = stb;
  endtask

  logic seen;
  int   ready_at[3];
  int   n_ready;

  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();

    // reset state
    check("rst_ready", rdy_a, 1'b0);
    check("rst_status", sts_a, 2'b00);
    check("rst_rdata", rd_a, 32'h0);
    check("rst_fwd", fwd_a, 32'h0);
    check("rst_fwm", fwm_a, 32'h0);
    check("rst_state", st_a, ST_IDLE);

    // range decode
    address = 16'h000C; #1 check("sel_0c", sel_a, 1'b0);
    address = 16'h0010; #1 check("sel_10", sel_a, 1'b1);
    address = 16'h001C; #1 check("sel_1c", sel_a, 1'b1);
    address = 16'h0020; #1 check("sel_20", sel_a, 1'b0);
    address = 16'h0040; #1 check("sel_b_40", sel_b, 1'b1);
    address = 16'h0044; #1 check("sel_b_44", sel_b, 1'b0);

    // zero-wait read with partial valid bits
    drive(16'h0040, 1'b0, 32'h0, 4'hF);
    field_read_data = 32'hDEAD_BEEF;
    exp_q.push_back(32'h0000_BEEF);
    req_c = 1'b1;
    tick();
    check("rd0_c0_pulse", frv_c, 1'b0);
    tick();
    check("rd0_c1_pulse", frv_c, 1'b1);
    check("rd0_c1_ready", rdy_c, 1'b0);
    tick();
    check("rd0_c2_ready", rdy_c, 1'b1);
    check("rd0_c2_status", sts_c, 2'b00);
    check("rd0_c2_rdata", rd_c, exp_q.pop_front());
    check("rd0_c2_pulse", frv_c, 1'b0);
    req_c = 1'b0;
    tick();
    check("rd0_after_ready", rdy_c, 1'b0);
    check("rd0_after_rdata", rd_c, 32'h0);

    // write with 3 wait states; bus changes during WAIT must be ignored
    drive(16'h0014, 1'b1, 32'h1234_5678, 4'b0101);
    req_a = 1'b1;
    tick();
    check("wr_c0_state", st_a, ST_WAIT);
    tick();
    drive(16'h0044, 1'b0, 32'hFFFF_FFFF, 4'hF);
    seen = 1'b0;
    for (int k = 2; k <= 3; k++) begin
      seen = seen | fwv_a;
      tick();
    end
    seen = seen | fwv_a;
    check("wr_no_early_pulse", seen, 1'b0);
    tick();
    check("wr_c4_pulse", fwv_a, 1'b1);
    check("wr_c4_data", fwd_a, 32'h1234_5678);
    check("wr_c4_mask", fwm_a, 32'h00FF_00FF);
    check("wr_c4_ready", rdy_a, 1'b0);
    tick();
    check("wr_c5_ready", rdy_a, 1'b1);
    check("wr_c5_status", sts_a, 2'b00);
    check("wr_c5_rdata", rd_a, 32'h0);
    check("wr_c5_pulse", fwv_a, 1'b0);
    req_a = 1'b0;
    tick();
    check("wr_idle", st_a, ST_IDLE);

    // denied write, error and okay flavours
    drive(16'h0040, 1'b1, 32'hCAFE_F00D, 4'hF);
    req_b = 1'b1;
    req_c = 1'b1;
    tick();
    seen = fwv_b | fwv_c;
    tick();
    seen = seen | fwv_b | fwv_c;
    check("den_b_ready", rdy_b, 1'b1);
    check("den_b_status", sts_b, 2'b10);
    check("den_c_ready", rdy_c, 1'b1);
    check("den_c_status", sts_c, 2'b00);
    check("den_c_rdata", rd_c, 32'h0);
    check("den_no_pulse", seen, 1'b0);
    req_b = 1'b0;
    req_c = 1'b0;
    tick();

    // read with 5 wait states aborted by request drop
    drive(16'h0040, 1'b0, 32'h0, 4'hF);
    req_b = 1'b1;
    tick();
    check("abt_c0_state", st_b, ST_WAIT);
    seen = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      seen = seen | frv_b | rdy_b;
    end
    req_b = 1'b0;
    tick();
    check("abt_state_idle", st_b, ST_IDLE);
    for (int k = 0; k < 8; k++) begin
      seen = seen | frv_b | rdy_b;
      tick();
    end
    check("abt_no_pulse_ready", seen, 1'b0);

    // next read on the same slot completes normally
    field_read_data = 32'hA5A5_5A5A;
    exp_q.push_back(32'hA5A5_5A5A);
    req_b = 1'b1;
    seen = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      tick();
      seen = seen | frv_b | rdy_b;
    end
    check("rd5_no_early", seen, 1'b0);
    tick();
    check("rd5_c6_pulse", frv_b, 1'b1);
    tick();
    check("rd5_c7_ready", rdy_b, 1'b1);
    check("rd5_c7_rdata", rd_b, exp_q.pop_front());
    req_b = 1'b0;
    tick();

    // held request: back-to-back reads, ready strobes W+3 apart
    drive(16'h001C, 1'b0, 32'h0, 4'hF);
    field_read_data = 32'h0BAD_F00D;
    n_ready = 0;
    for (int k = 0; k < 3; k++) ready_at[k] = -1;
    req_a = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (rdy_a && n_ready < 3) begin
        ready_at[n_ready] = t;
        n_ready++;
      end
    end
    req_a = 1'b0;
    check("held_first_ready", ready_at[0], 3);
    check("held_gap_1", ready_at[1] - ready_at[0], 4);
    check("held_gap_2", ready_at[2] - ready_at[1], 4);
    for (int k = 0; k < 6; k++) tick();
    check("held_drain_idle", st_a, ST_IDLE);

    // reset while in ACCESS
    drive(16'h0018, 1'b0, 32'h0, 4'hF);
    req_a = 1'b1;
    tick();
    tick();
    check("rst_mid_in_access", st_a, ST_ACCESS);
    check("rst_mid_mask_set", fwm_a, 32'hFFFF_FFFF);
    rst = 1'b1;
    #1;
    check("rst_mid_state", st_a, ST_IDLE);
    check("rst_mid_ready", rdy_a, 1'b0);
    check("rst_mid_pulse", frv_a, 1'b0);
    check("rst_mid_mask", fwm_a, 32'h0);
    req_a = 1'b0;
    #2;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen = seen | rdy_a | frv_a | fwv_a;
    end
    check("rst_mid_no_response", seen, 1'b0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rggen_wait_state_register.md
# rggen_wait_state_register

Register-slot front end with programmable wait states and access-permission checking. It decodes an address range, runs a small FSM that inserts READ_WAIT/WRITE_WAIT cycles, issues a single-cycle access pulse to the field logic, and returns registered ready, status and read data. It sits between the register-block bus splitter and the field instances of one register, one instance per register.

## Interface
- ADDRESS_WIDTH, 16, byte-address width
- START_ADDRESS, '0, first byte address of the register
- END_ADDRESS, '0, last byte address of the register
- DATA_WIDTH, 32, bus/register width; multiple of 8
- VALID_BITS, '1, implemented bit mask; unimplemented bits read 0 and are never written
- READABLE, 1, reads permitted
- WRITABLE, 1, writes permitted
- READ_WAIT, 0, wait cycles before a read access (0..255)
- WRITE_WAIT, 0, wait cycles before a write access (0..255)
- ERROR_ON_DENIED, 1, denied access answers SLVERR (1) or OKAY with no effect (0)

Ports:
- i_clk, input, 1, clock
- i_rst, input, 1, asynchronous active-high reset
- i_request, input, 1, host request, held until o_ready
- i_address, input, ADDRESS_WIDTH, byte address
- i_write, input, 1, 1 = write, 0 = read
- i_write_data, input, DATA_WIDTH, write data
- i_strobe, input, DATA_WIDTH/8, byte enables
- o_select, output, 1, combinational address hit
- o_ready, output, 1, one-cycle response strobe
- o_status, output, 2, 2'b00 OKAY, 2'b10 SLVERR
- o_read_data, output, DATA_WIDTH, read data, valid with o_ready
- o_field_read_valid, output, 1, one-cycle read pulse to the fields
- o_field_write_valid, output, 1, one-cycle write pulse to the fields
- o_field_write_data, output, DATA_WIDTH, i_write_data & VALID_BITS (latched)
- o_field_write_mask, output, DATA_WIDTH, byte-expanded strobe & VALID_BITS (latched)
- i_field_read_data, input, DATA_WIDTH, field read value

## Operation
- Decode uses only address bits [ADDRESS_WIDTH-1:LSB], where LSB = $clog2(DATA_WIDTH/8).
  - If the start and end word addresses are equal, o_select is an equality compare.
  - Otherwise o_select is an inclusive range compare.
- Hit means i_request & o_select.
- FSM states: IDLE, WAIT, ACCESS, RESPOND.
  - IDLE, on hit: latch write, data and mask.
    - Denied access (write with WRITABLE=0, or read with READABLE=0) goes to RESPOND.
    - Otherwise, if the applicable wait count is 0, go to ACCESS.
    - Otherwise load the counter with wait-1 and go to WAIT.
  - WAIT: decrement the counter. When it is 0, go to ACCESS. If i_request drops, go to IDLE (abort: no pulse, no ready).
  - ACCESS: o_field_read_valid or o_field_write_valid is high for exactly this cycle. On a read, capture i_field_read_data & VALID_BITS. Always go to RESPOND, regardless of i_request.
  - RESPOND: o_ready=1 for one cycle, then go to IDLE.
- Denied access:
  - o_status=2'b10 if ERROR_ON_DENIED, else 2'b00.
  - o_read_data=0 and no field pulse in either case.
- o_read_data is 0 in every cycle except a read RESPOND.
- Counter width is $clog2(max(READ_WAIT, WRITE_WAIT)+1), minimum 1.
- Address, write and data changes after the IDLE capture are ignored.

## Timing
- Cycle 0 is the first edge at which a hit is seen in IDLE.
- Permitted access: the field pulse is in cycle W+1 and o_ready in cycle W+2, where W is the applicable wait.
- Denied access: o_ready in cycle 1.
- If i_request is still high in the cycle after RESPOND, it is treated as a new access. The minimum spacing between ready strobes is W+3 cycles.
- Reset values: o_ready=0, o_status=2'b00, o_read_data=0, both field valids 0, write data and mask 0, state IDLE, counter 0.
- o_select is combinational and is the only unregistered output.
- Reset asserted mid-operation forces IDLE immediately. The pending response is dropped, and a field pulse in flight is cut off at the reset edge.

## Test plan
- READ_WAIT=0, read at START_ADDRESS, i_field_read_data=32'hDEADBEEF, VALID_BITS=32'h0000FFFF -> read pulse in cycle 1, o_ready in cycle 2, o_read_data=32'h0000BEEF, o_status=00.
- WRITE_WAIT=3, write 32'h12345678 with strobe 4'b0101 -> write pulse in cycle 4 with mask 32'h00FF00FF, o_ready in cycle 5.
- WRITABLE=0, write, with ERROR_ON_DENIED=1 then 0 -> o_ready in cycle 1 with status 10 then 00; no write pulse in either case.
- READ_WAIT=5, drop i_request in cycle 3 -> no read pulse, no o_ready, FSM back in IDLE; the next request completes normally.
- Range START=0x10, END=0x1C (32-bit) -> o_select=1 for 0x10 and 0x1C, 0 for 0x0C and 0x20; i_request held high yields ready strobes spaced W+3 cycles apart.
- Assert i_rst in the ACCESS cycle -> all outputs 0 immediately, no o_ready afterward.
